// File: rtl/lcd_bus_driver.sv
// lcd_bus_driver
// HD44780-compatible character-LCD bus driver. After power-up it waits for the
// panel to settle, plays a fixed four-write init sequence, then loops forever:
// request a 12-bit command word from upstream with a two-cycle rdy pulse,
// decode it into at most one timed bus write, and hold off for the
// controller's execution time before asking for the next word.
//
// Every timed state is driven by a single shared 20-bit down-counter that is
// loaded with (duration - 1) on entry and advances on zero. A duration of 0
// behaves like 1. All outputs are registered from the next-state value so the
// pins change on the same edge the FSM enters the corresponding state.

module lcd_bus_driver #(
  parameter logic [19:0] T_PWRUP = 20'd750_000,
  parameter logic [19:0] T_SETUP = 20'd4,
  parameter logic [19:0] T_EN    = 20'd12,
  parameter logic [19:0] T_HOLD  = 20'd4,
  parameter logic [19:0] T_CMD   = 20'd2_000,
  parameter logic [19:0] T_CLEAR = 20'd82_000,
  parameter logic [19:0] T_POLL  = 20'd2_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] cmd_word,
  output logic        rdy,
  output logic        init_done,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        lcd_on
);

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_SETUP,
    ST_EN,
    ST_HOLD,
    ST_XWAIT,
    ST_REQ,
    ST_FETCH,
    ST_POLL
  } state_t;

  // Number of cycles rdy stays high in REQ.
  localparam logic [19:0] L_REQ_LEN = 20'd2;

  // Counter preload for the power-up wait, used directly by reset.
  localparam logic [19:0] L_PWRUP_LOAD = (T_PWRUP == 20'd0) ? 20'd0 : (T_PWRUP - 20'd1);

  // Opcodes carried in cmd_word[11:8].
  localparam logic [3:0] OP_CLEAR = 4'h0;
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_SETCG = 4'h2;
  localparam logic [3:0] OP_SETAD = 4'h3;

  // HD44780 instruction byte that clears the display (needs the long wait).
  localparam logic [7:0] B_CLEAR = 8'h01;

  state_t      r_state;
  state_t      w_stateNext;
  logic [19:0] r_cnt;
  logic        w_cntDone;

  logic [1:0]  r_initIdx;
  logic        r_initDone;
  logic        r_rdy;
  logic        r_en;
  logic [7:0]  r_data;
  logic        r_rs;
  logic        r_clearWait;

  logic        w_cmdIsBus;
  logic        w_cmdRs;
  logic [7:0]  w_cmdByte;
  logic        w_cmdClear;

  logic        w_busLoad;
  logic [7:0]  w_busByte;
  logic        w_busRs;
  logic        w_busClear;
  logic        w_initAdvance;
  logic        w_initFinish;

  // Power-on initialisation bytes: function set (8-bit, 2 lines, 5x8),
  // display on with cursor off, entry mode increment, clear display.
  function automatic logic [7:0] initRom(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = 8'h38;
      2'd1:    b = 8'h0C;
      2'd2:    b = 8'h06;
      default: b = B_CLEAR;
    endcase
    return b;
  endfunction

  // Counter preload for a given state; the XWAIT length depends on whether
  // the write that preceded it was a clear-display instruction.
  function automatic logic [19:0] loadOf(input state_t s, input logic clearWait);
    logic [19:0] d;
    case (s)
      ST_PWRUP: d = T_PWRUP;
      ST_SETUP: d = T_SETUP;
      ST_EN:    d = T_EN;
      ST_HOLD:  d = T_HOLD;
      ST_XWAIT: d = clearWait ? T_CLEAR : T_CMD;
      ST_REQ:   d = L_REQ_LEN;
      ST_POLL:  d = T_POLL;
      default:  d = 20'd1;
    endcase
    return (d == 20'd0) ? 20'd0 : (d - 20'd1);
  endfunction

  assign w_cntDone = (r_cnt == 20'd0);

  // Decode the upstream command word into the bus write it asks for; only
  // consulted while the FSM sits in FETCH.
  always_comb begin
    w_cmdIsBus = 1'b1;
    w_cmdRs    = 1'b0;
    w_cmdByte  = 8'h00;
    w_cmdClear = 1'b0;
    case (cmd_word[11:8])
      OP_CLEAR: begin
        w_cmdByte  = B_CLEAR;
        w_cmdClear = 1'b1;
      end
      OP_WRITE: begin
        w_cmdRs   = 1'b1;
        w_cmdByte = cmd_word[7:0];
      end
      OP_SETCG: begin
        w_cmdByte = {2'b01, cmd_word[5:0]};
      end
      OP_SETAD: begin
        w_cmdByte = {1'b1, cmd_word[6:0]};
      end
      default: begin
        w_cmdIsBus = 1'b0;
      end
    endcase
  end

  // Next-state logic, plus the strobes that load a new bus byte and step
  // the init sequence.
  always_comb begin
    w_stateNext   = r_state;
    w_busLoad     = 1'b0;
    w_busByte     = r_data;
    w_busRs       = r_rs;
    w_busClear    = r_clearWait;
    w_initAdvance = 1'b0;
    w_initFinish  = 1'b0;

    case (r_state)
      ST_PWRUP: begin
        if (w_cntDone) begin
          w_stateNext = ST_SETUP;
          w_busLoad   = 1'b1;
          w_busByte   = initRom(r_initIdx);
          w_busRs     = 1'b0;
          w_busClear  = (initRom(r_initIdx) == B_CLEAR);
        end
      end

      ST_SETUP: begin
        if (w_cntDone) begin
          w_stateNext = ST_EN;
        end
      end

      ST_EN: begin
        if (w_cntDone) begin
          w_stateNext = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (w_cntDone) begin
          w_stateNext = ST_XWAIT;
        end
      end

      ST_XWAIT: begin
        if (w_cntDone) begin
          if (r_initDone) begin
            w_stateNext = ST_REQ;
          end else if (r_initIdx == 2'd3) begin
            w_stateNext  = ST_REQ;
            w_initFinish = 1'b1;
          end else begin
            w_stateNext   = ST_SETUP;
            w_initAdvance = 1'b1;
            w_busLoad     = 1'b1;
            w_busByte     = initRom(r_initIdx + 2'd1);
            w_busRs       = 1'b0;
            w_busClear    = (initRom(r_initIdx + 2'd1) == B_CLEAR);
          end
        end
      end

      ST_REQ: begin
        if (w_cntDone) begin
          w_stateNext = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (w_cmdIsBus) begin
          w_stateNext = ST_SETUP;
          w_busLoad   = 1'b1;
          w_busByte   = w_cmdByte;
          w_busRs     = w_cmdRs;
          w_busClear  = w_cmdClear;
        end else begin
          w_stateNext = ST_POLL;
        end
      end

      ST_POLL: begin
        if (w_cntDone) begin
          w_stateNext = ST_REQ;
        end
      end

      default: begin
        w_stateNext = ST_PWRUP;
      end
    endcase
  end

  // State register and the shared duration counter, reloaded on every
  // state change and otherwise counting down to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_PWRUP;
      r_cnt   <= L_PWRUP_LOAD;
    end else begin
      r_state <= w_stateNext;
      if (w_stateNext != r_state) begin
        r_cnt <= loadOf(w_stateNext, w_busClear);
      end else if (!w_cntDone) begin
        r_cnt <= r_cnt - 20'd1;
      end
    end
  end

  // Init sequence position and the sticky init-complete flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_initIdx  <= 2'd0;
      r_initDone <= 1'b0;
    end else begin
      if (w_initAdvance) begin
        r_initIdx <= r_initIdx + 2'd1;
      end
      if (w_initFinish) begin
        r_initDone <= 1'b1;
      end
    end
  end

  // Bus byte, register select and wait-length select; loaded when a write
  // starts and held until the next one so POLL leaves the bus untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data      <= 8'h00;
      r_rs        <= 1'b0;
      r_clearWait <= 1'b0;
    end else if (w_busLoad) begin
      r_data      <= w_busByte;
      r_rs        <= w_busRs;
      r_clearWait <= w_busClear;
    end
  end

  // Strobe outputs, registered from the next state so they line up with
  // the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdy <= 1'b0;
      r_en  <= 1'b0;
    end else begin
      r_rdy <= (w_stateNext == ST_REQ);
      r_en  <= (w_stateNext == ST_EN);
    end
  end

  assign rdy       = r_rdy;
  assign init_done = r_initDone;
  assign lcd_data  = r_data;
  assign lcd_rs    = r_rs;
  assign lcd_en    = r_en;
  assign lcd_rw    = 1'b0;
  assign lcd_on    = 1'b1;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// tb_lcd_bus_driver
// Self-checking bench for lcd_bus_driver. A fixed table of command words and
// a batch of random words are played through an upstream model that answers
// each rdy pulse; strobes, latencies and held bus values are compared with
// values worked out from the timing rules using plain arithmetic.

module tb_lcd_bus_driver;

  localparam int P_PWRUP = 100;
  localparam int P_SETUP = 2;
  localparam int P_EN    = 4;
  localparam int P_HOLD  = 2;
  localparam int P_CMD   = 10;
  localparam int P_CLEAR = 50;
  localparam int P_POLL  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] cmd_word = 12'h000;
  logic        rdy;
  logic        init_done;
  logic [7:0]  lcd_data;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_en;
  logic        lcd_on;

  lcd_bus_driver #(
    .T_PWRUP(20'(P_PWRUP)),
    .T_SETUP(20'(P_SETUP)),
    .T_EN   (20'(P_EN)),
    .T_HOLD (20'(P_HOLD)),
    .T_CMD  (20'(P_CMD)),
    .T_CLEAR(20'(P_CLEAR)),
    .T_POLL (20'(P_POLL))
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_word (cmd_word),
    .rdy      (rdy),
    .init_done(init_done),
    .lcd_data (lcd_data),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_en   (lcd_en),
    .lcd_on   (lcd_on)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Count of clock edges since reset was released.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    int         cycle;
    logic [7:0] data;
    logic       rs;
  } strobe_t;

  typedef struct {
    logic [11:0] word;
    bit          bus;
    logic        rs;
    logic [7:0]  data;
    int          latency;
    bit          scramble;
  } vec_t;

  int checkCount = 0;
  int errorCount = 0;

  strobe_t enRises[$];
  int      enWidths[$];
  logic    prevEn = 1'b0;
  logic    prevRdy = 1'b0;
  int      enRun = 0;
  int      rdyRun = 0;
  int      rdyWidthLast = 0;
  int      enUnstable = 0;
  int      rdyBeforeInit = 0;
  bit      rdyRose = 1'b0;

  vec_t table_q[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Advance to the next falling edge and log what the bus did this cycle.
  task automatic sampleCycle();
    strobe_t s;
    @(negedge clk);
    rdyRose = rdy && !prevRdy;
    if (lcd_en && !prevEn) begin
      s.cycle = cyc;
      s.data  = lcd_data;
      s.rs    = lcd_rs;
      enRises.push_back(s);
      enRun = 0;
    end
    if (lcd_en) begin
      enRun++;
      if (enRises.size() > 0) begin
        if (lcd_data !== enRises[$].data || lcd_rs !== enRises[$].rs) enUnstable++;
      end
    end
    if (!lcd_en && prevEn) enWidths.push_back(enRun);
    if (rdyRose) rdyRun = 0;
    if (rdy) rdyRun++;
    if (!rdy && prevRdy) rdyWidthLast = rdyRun;
    if (rdy && !init_done) rdyBeforeInit++;
    prevEn  = lcd_en;
    prevRdy = rdy;
  endtask

  // Expected behaviour of one command word, straight from the opcode rules.
  function automatic vec_t refModel(input logic [11:0] w, input bit scramble);
    vec_t v;
    int op;
    int arg;
    int writeTime;
    op  = int'(w[11:8]);
    arg = int'(w[7:0]);
    writeTime = 1 + P_SETUP + P_EN + P_HOLD;
    v.word = w;
    v.scramble = scramble;
    v.bus = 1'b1;
    v.rs  = 1'b0;
    v.data = 8'h00;
    v.latency = writeTime + P_CMD;
    if (op == 0) begin
      v.data = 8'h01;
      v.latency = writeTime + P_CLEAR;
    end else if (op == 1) begin
      v.rs = 1'b1;
      v.data = 8'(arg);
    end else if (op == 2) begin
      v.data = 8'(64 + arg % 64);
    end else if (op == 3) begin
      v.data = 8'(128 + arg % 128);
    end else begin
      v.bus = 1'b0;
      v.latency = 1 + P_POLL;
    end
    return v;
  endfunction

  function automatic vec_t mkVec(input logic [11:0] w, input bit bus, input logic rs,
                                 input logic [7:0] data, input int latency, input bit scramble);
    vec_t v;
    v.word = w;
    v.bus = bus;
    v.rs = rs;
    v.data = data;
    v.latency = latency;
    v.scramble = scramble;
    return v;
  endfunction

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " rdy"}, 32'(rdy), 32'd0);
    checkOutput({tag, " init_done"}, 32'(init_done), 32'd0);
    checkOutput({tag, " lcd_data"}, 32'(lcd_data), 32'h00);
    checkOutput({tag, " lcd_rs"}, 32'(lcd_rs), 32'd0);
    checkOutput({tag, " lcd_rw"}, 32'(lcd_rw), 32'd0);
    checkOutput({tag, " lcd_en"}, 32'(lcd_en), 32'd0);
    checkOutput({tag, " lcd_on"}, 32'(lcd_on), 32'd1);
  endtask

  // Run from reset release to init_done and compare the init sequence.
  task automatic checkPowerUp(input string tag);
    logic [7:0] initBytes [4];
    int expRise [4];
    int t;
    bit got;
    initBytes[0] = 8'h38;
    initBytes[1] = 8'h0C;
    initBytes[2] = 8'h06;
    initBytes[3] = 8'h01;
    enRises.delete();
    enWidths.delete();
    rdyBeforeInit = 0;
    enUnstable = 0;
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      sampleCycle();
      if (init_done) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput({tag, " init_done reached"}, 32'(got), 32'd1);
    if (!got) return;

    t = P_PWRUP;
    for (int k = 0; k < 4; k++) begin
      expRise[k] = t + P_SETUP;
      t += P_SETUP + P_EN + P_HOLD + ((initBytes[k] == 8'h01) ? P_CLEAR : P_CMD);
    end
    checkOutput({tag, " init_done cycle"}, 32'(cyc), 32'(t));
    checkOutput({tag, " init strobe count"}, 32'(enRises.size()), 32'd4);
    for (int k = 0; k < 4 && k < enRises.size(); k++) begin
      checkOutput($sformatf("%s init%0d rise cycle", tag, k), 32'(enRises[k].cycle), 32'(expRise[k]));
      checkOutput($sformatf("%s init%0d data", tag, k), 32'(enRises[k].data), 32'(initBytes[k]));
      checkOutput($sformatf("%s init%0d rs", tag, k), 32'(enRises[k].rs), 32'd0);
      if (k < enWidths.size())
        checkOutput($sformatf("%s init%0d en width", tag, k), 32'(enWidths[k]), 32'(P_EN));
    end
    checkOutput({tag, " init bus stable"}, 32'(enUnstable), 32'd0);
    checkOutput({tag, " rdy before init"}, 32'(rdyBeforeInit), 32'd0);
    checkOutput({tag, " rdy rises with init_done"}, 32'(rdyRose), 32'd1);
    checkOutput({tag, " lcd_rw"}, 32'(lcd_rw), 32'd0);
    checkOutput({tag, " lcd_on"}, 32'(lcd_on), 32'd1);
  endtask

  // Answer the rdy pulse that just rose with one command word, follow it to
  // the next rdy rise and compare what happened on the bus.
  task automatic applyStimulus(input vec_t v);
    int rr;
    int fetchCyc;
    bit got;
    logic [7:0] dataBefore;
    string tag;
    tag = $sformatf("cmd %03h", v.word);
    rr = cyc;
    fetchCyc = rr + 2;
    dataBefore = lcd_data;
    cmd_word = v.word;
    enRises.delete();
    enWidths.delete();
    enUnstable = 0;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      sampleCycle();
      if (rdyRose) begin
        got = 1'b1;
        break;
      end
      if (v.scramble && cyc >= rr + 3) cmd_word = 12'($urandom);
    end
    checkOutput({tag, " next rdy seen"}, 32'(got), 32'd1);
    if (!got) return;
    checkOutput({tag, " latency"}, 32'(cyc - fetchCyc), 32'(v.latency));
    checkOutput({tag, " rdy width"}, 32'(rdyWidthLast), 32'd2);
    checkOutput({tag, " strobe count"}, 32'(enRises.size()), v.bus ? 32'd1 : 32'd0);
    if (v.bus && enRises.size() == 1) begin
      checkOutput({tag, " data"}, 32'(enRises[0].data), 32'(v.data));
      checkOutput({tag, " rs"}, 32'(enRises[0].rs), 32'(v.rs));
      checkOutput({tag, " en rise cycle"}, 32'(enRises[0].cycle), 32'(fetchCyc + 1 + P_SETUP));
      checkOutput({tag, " en width"}, (enWidths.size() > 0) ? 32'(enWidths[0]) : 32'd0, 32'(P_EN));
      checkOutput({tag, " bus stable"}, 32'(enUnstable), 32'd0);
    end
    checkOutput({tag, " data held"}, 32'(lcd_data), v.bus ? 32'(v.data) : 32'(dataBefore));
  endtask

  // Pull reset in the middle of a strobe and confirm the outputs clear
  // without waiting for a clock edge, then replay power-up.
  task automatic midStrobeReset();
    bit got;
    cmd_word = 12'h141;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      sampleCycle();
      if (lcd_en) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("mid-reset strobe seen", 32'(got), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkResetValues("async reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    prevEn = 1'b0;
    prevRdy = 1'b0;
    rdyRun = 0;
    checkPowerUp("repowerup");
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, %0d checks so far", checkCount);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t rv;

    table_q.push_back(mkVec(12'h141, 1'b1, 1'b1, 8'h41, 19, 1'b0));
    table_q.push_back(mkVec(12'h3C5, 1'b1, 1'b0, 8'hC5, 19, 1'b0));
    table_q.push_back(mkVec(12'h2FF, 1'b1, 1'b0, 8'h7F, 19, 1'b0));
    table_q.push_back(mkVec(12'h000, 1'b1, 1'b0, 8'h01, 59, 1'b0));
    table_q.push_back(mkVec(12'hF00, 1'b0, 1'b0, 8'h00, 9, 1'b0));
    table_q.push_back(mkVec(12'h700, 1'b0, 1'b0, 8'h00, 9, 1'b0));
    table_q.push_back(mkVec(12'h4AA, 1'b0, 1'b0, 8'h00, 9, 1'b0));
    table_q.push_back(mkVec(12'h380, 1'b1, 1'b0, 8'h80, 19, 1'b0));
    table_q.push_back(mkVec(12'h15A, 1'b1, 1'b1, 8'h5A, 19, 1'b1));
    table_q.push_back(mkVec(12'h000, 1'b1, 1'b0, 8'h01, 59, 1'b1));
    table_q.push_back(mkVec(12'hF12, 1'b0, 1'b0, 8'h00, 9, 1'b1));
    table_q.push_back(mkVec(12'h23C, 1'b1, 1'b0, 8'h7C, 19, 1'b1));

    #23;
    checkResetValues("reset");
    @(negedge clk);
    rst = 1'b0;
    checkPowerUp("powerup");

    for (int i = 0; i < table_q.size(); i++) begin
      applyStimulus(table_q[i]);
    end

    for (int i = 0; i < 12; i++) begin
      rv = refModel(12'($urandom), 1'($urandom_range(0, 1)));
      applyStimulus(rv);
    end

    midStrobeReset();
    applyStimulus(mkVec(12'h3C5, 1'b1, 1'b0, 8'hC5, 19, 1'b0));
    applyStimulus(mkVec(12'hF00, 1'b0, 1'b0, 8'h00, 9, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
